neuron_mac: RTL and testbench

Fixed-point neuron accumulator that computes one weighted sum, bias + Σ xᵢ·wᵢ, over `N_INPUTS` serially presented input/weight pairs. It produces the saturated 16-bit Q6.10 pre-activation value (1024 = 1.0) that feeds the sigmoid activation stage directly downstream. The block is sequential: it uses a start/valid/ready handshake on both sides and a single shared multiplier, so one pair is accumulated per cycle.

---
 rtl/neuron_mac.sv | 130 +++++++++++++
 tb/tb_neuron_mac.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: fixed-point neuron accumulator.
//
// Computes sum = sat16(bias + sum_i (x_i * w_i) >> FRAC_BITS) over N_INPUTS
// serially presented x/w pairs. The result is a saturated Q6.10 value that
// feeds the sigmoid stage. A single multiplier accumulates one pair per cycle.
//
// Handshakes: a transfer happens on a cycle where both valid and ready are
// high at the rising clock edge. The input side uses in_valid/in_ready. The
// output side uses out_valid/out_ready. in_ready and out_valid are pure
// decodes of the registered state, so neither depends combinationally on
// the other side's valid or ready.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, bias     begin a sum (sampled in IDLE), Q6.10 bias captured with it
//   in_valid/ready  x/w pair handshake
//   x, w            Q6.10 activation and weight
//   out_valid/ready result handshake
//   sum             saturated Q6.10 result, held while out_valid is high
//   busy            high in any state other than IDLE
//   state_dbg       current FSM state (0 IDLE, 1 ACCUM, 2 SAT, 3 DONE)
//
// Build option: define NEURON_MAC_ROUND_EN to round each product term
// half-up instead of truncating it toward minus infinity.
module neuron_mac #(
  parameter int N_INPUTS  = 2,
  parameter int FRAC_BITS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x,
  input  logic signed [15:0] w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] sum,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = $clog2(N_INPUTS + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic signed [31:0] acc;
  logic signed [31:0] prod;
  logic signed [31:0] term;
  logic signed [15:0] sat_val;
  logic               accept;
  logic               last;

  // The low 32 bits of a product do not depend on signedness, so the
  // operands are sign-extended by hand to keep every width explicit.
  assign prod = {{16{x[15]}}, x} * {{16{w[15]}}, w};

`ifdef NEURON_MAC_ROUND_EN
  localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC_BITS - 1);
  // |prod| <= 2^30, so adding half an LSB cannot overflow 32 bits.
  assign term = (prod + HALF) >>> FRAC_BITS;
`else
  assign term = prod >>> FRAC_BITS;
`endif

  assign accept    = in_valid && (state == ACCUM);
  assign last      = (cnt == CW'(N_INPUTS - 1));

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Saturation is applied once to the full-width sum, not to each term.
  always_comb begin
    if (acc > 32'sd32767)
      sat_val = 16'sh7fff;
    else if (acc < -32'sd32768)
      sat_val = 16'sh8000;
    else
      sat_val = acc[15:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && last) state_nxt = SAT;
      SAT:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc <= {{16{bias[15]}}, bias};
            cnt <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + term;
            cnt <= cnt + CW'(1);
          end
        end
        SAT:     sum <= sat_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed testbench for neuron_mac (N_INPUTS=2, FRAC_BITS=10).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_neuron_mac;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x;
  logic signed [15:0] w;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] sum;
  logic               busy;
  logic [1:0]         state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  neuron_mac #(.N_INPUTS(2), .FRAC_BITS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    bias  = 16'h0bad;
  endtask

  // Presents one pair for exactly one accepted cycle; waits (bounded) for in_ready.
  task automatic send_pair(input logic [15:0] xv, input logic [15:0] wv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1;
    x        = xv;
    w        = wv;
    tick();
    in_valid = 1'b0;
    x        = 16'h1234;
    w        = 16'h4321;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: got out_valid=%0b want 1", out_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (sum !== 16'sd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", sum); end
  endtask

  // bias -2.5 + 1.0*5.0 + 0*5.0 = 2.5 -> 2560
  task automatic test_xor();
    logic [15:0] e;
    exp_q.push_back(16'd2560);
    out_ready = 1'b1;
    do_start(16'hf600);                 // -2560
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL xor_ready_after_start: got %0b want 1", in_ready); end
    send_pair(16'd1024, 16'd5120);
    send_pair(16'd0, 16'd5120);
    // cycle L+1: SAT
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++;
      $display("FAIL xor_sat_cycle: got out_valid=%0b in_ready=%0b want 0 0", out_valid, in_ready); end
    tick();
    // cycle L+2: DONE
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL xor_latency: got out_valid=%0b want 1", out_valid); end
    total++; if (sum !== e) begin bad++; $display("FAIL xor_sum: got %0d want %0d", sum, $signed(e)); end
    tick();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL xor_back_to_idle: got busy=%0b out_valid=%0b want 0 0", busy, out_valid); end
  endtask

  // 32767*32767>>10 = 1048512 per term -> clamps high;
  // -32768*32767>>10 = -1048544 per term -> clamps low.
  task automatic test_saturation();
    logic [15:0] e;
    exp_q.push_back(16'h7fff);
    exp_q.push_back(16'h8000);
    out_ready = 1'b1;
    do_start(16'd0);
    send_pair(16'h7fff, 16'h7fff);
    send_pair(16'h7fff, 16'h7fff);
    wait_out();
    e = exp_q.pop_front();
    total++; if (sum !== e) begin bad++; $display("FAIL sat_pos: got %0d want %0d", sum, $signed(e)); end
    tick();
    do_start(16'd0);
    send_pair(16'h8000, 16'h7fff);
    send_pair(16'h8000, 16'h7fff);
    wait_out();
    e = exp_q.pop_front();
    total++; if (sum !== e) begin bad++; $display("FAIL sat_neg: got %0d want %0d", sum, $signed(e)); end
    tick();
  endtask

  // (-1)*1 = -1 in Q12.20: floor gives -1, round-half-up gives 0.
  task automatic test_rounding();
    logic [15:0] e;
`ifdef NEURON_MAC_ROUND_EN
    exp_q.push_back(16'h0000);
`else
    exp_q.push_back(16'hffff);
`endif
    out_ready = 1'b1;
    do_start(16'd0);
    send_pair(16'hffff, 16'd1);
    send_pair(16'd0, 16'd0);
    wait_out();
    e = exp_q.pop_front();
    total++; if (sum !== e) begin bad++; $display("FAIL rounding_sum: got %0d want %0d", sum, $signed(e)); end
    tick();
  endtask

  // 100 + 2048*1024>>10 (=2048) + (-512)*2048>>10 (=-1024) = 1124
  task automatic test_gapped_backpressure();
    logic [15:0] e;
    exp_q.push_back(16'd1124);
    out_ready = 1'b0;
    do_start(16'd100);
    send_pair(16'd2048, 16'd1024);
    // gap: junk data with in_valid low must not count
    x = 16'd7000;
    w = 16'd7000;
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL gap_still_accum: got in_ready=%0b want 1", in_ready); end
    send_pair(16'hfe00, 16'd2048);      // -512
    tick();
    e = exp_q.pop_front();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gap_out_valid: got %0b want 1", out_valid); end
    total++; if (sum !== e) begin bad++; $display("FAIL gap_sum: got %0d want %0d", sum, $signed(e)); end
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      bias     = 16'd999;
      in_valid = 1'b1;
      x        = 16'h4000;
      w        = 16'h4000;
      tick();
      total++; if (out_valid !== 1'b1 || sum !== e || in_ready !== 1'b0) begin bad++;
        $display("FAIL stall_stable[%0d]: got out_valid=%0b sum=%0d in_ready=%0b want 1 %0d 0",
                 i, out_valid, sum, in_ready, $signed(e)); end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++;
      $display("FAIL stall_release_idle: got busy=%0b out_valid=%0b want 0 0", busy, out_valid); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_start_ignored: got busy=%0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    out_ready = 1'b1;
    do_start(16'd500);
    send_pair(16'd1024, 16'd2048);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'sd0) begin bad++;
      $display("FAIL reset_mid_outputs: got in_ready=%0b out_valid=%0b busy=%0b sum=%0d want 0 0 0 0",
               in_ready, out_valid, busy, sum); end
    // fresh sum: 1.0 + 1.0*1.0 + 1.0*1.0 = 3.0
    exp_q.push_back(16'd3072);
    do_start(16'd1024);
    send_pair(16'd1024, 16'd1024);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_count: got in_ready=%0b want 1", in_ready); end
    send_pair(16'd1024, 16'd1024);
    wait_out();
    e = exp_q.pop_front();
    total++; if (sum !== e) begin bad++; $display("FAIL reset_mid_fresh_sum: got %0d want %0d", sum, $signed(e)); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    x         = '0;
    w         = '0;
    out_ready = 1'b1;
    test_reset();
    test_xor();
    test_saturation();
    test_rounding();
    test_gapped_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
